// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC exponent scheduler slice.
// - Scheduler state encoding.
// - Default operand/result widths, engine iteration count and watchdog limit.
package cordic_pkg;

  localparam int XW_DEF      = 32;  // engine operand width
  localparam int YW_DEF      = 64;  // engine result width
  localparam int ENG_ITERS   = 32;  // table-walk steps inside the engine
  localparam int TIMEOUT_DEF = 40;  // WAIT cycles before the engine is declared hung

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/cordic_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans the request vector starting at ptr, wrapping modulo NREQ, and grants
// the first set bit. The pointer itself is owned by the caller.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  IDW   index to start the scan at (must be < NREQ)
//   en    in  1     arbitration enable; grant is all-zero when low
//   grant out NREQ  one-hot grant (all-zero if nothing granted)
//   idx   out IDW   encoded index of the granted requester
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  always_comb begin : scan
    int   c;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < NREQ; i++) begin
      // Candidate index wraps explicitly so NREQ need not be a power of two.
      c = int'(ptr) + i;
      if (c >= NREQ) c = c - NREQ;
      if (en && !found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Scheduler sharing one iterative CORDIC exponent engine between NREQ
// requesters. Requests are granted round-robin; the engine is walked through
// preload (LOAD), start (START), completion wait (WAIT) and the result is
// presented on the response port (RESP) tagged with the requester index.
// A watchdog recovers a hung engine with an error response.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_valid    per-requester request pending
//   req_x        packed operands, requester i at [i*XW +: XW]
//   req_ready    one-hot pulse: that requester's operand is captured this cycle
//   rsp_valid    response available; rsp_ready accepts it
//   rsp_id       index of the requester the response belongs to
//   rsp_y        result (0 on timeout)
//   rsp_err      engine timed out
//   eng_rst      engine preload strobe (also held during rst, pulsed on timeout)
//   eng_en       engine start strobe
//   eng_x        operand to engine (valid LOAD..WAIT, 0 otherwise)
//   eng_y        engine result, qualified by eng_valid
//   eng_valid    engine done pulse
//   busy         scheduler not idle
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int XW      = XW_DEF,
  parameter int YW      = YW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*XW-1:0]      req_x,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [YW-1:0]           rsp_y,
  output logic                    rsp_err,
  output logic                    eng_rst,
  output logic                    eng_en,
  output logic [XW-1:0]           eng_x,
  input  logic [YW-1:0]           eng_y,
  input  logic                    eng_valid,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt;
  logic [WDW-1:0]  wd;

  logic [XW-1:0]   op_sel;
  logic [XW-1:0]   op_reg;
  logic [IDW-1:0]  id_reg;
  logic [YW-1:0]   y_reg;
  logic            err_reg;

  logic            arb_en;
  logic            grant_fire;
  logic            done_fire;
  logic            timeout_fire;

  // Arbitration only runs in IDLE and never while reset is held.
  assign arb_en       = (state == ST_IDLE) && !rst;
  assign grant_fire   = |gnt;
  assign done_fire    = (state == ST_WAIT) && eng_valid;
  // Fires on the TIMEOUT-th WAIT cycle (watchdog counts 0..TIMEOUT-1).
  assign timeout_fire = (state == ST_WAIT) && !eng_valid && (wd == WD_LAST);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (arb_en),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  // Only the granted requester's operand is ever selected.
  always_comb begin
    op_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) op_sel = req_x[i*XW +: XW];
    end
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_fire) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (done_fire || timeout_fire) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---- control registers: arbiter pointer and watchdog ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      wd  <= '0;
    end else begin
      if (grant_fire) ptr <= (gnt_idx == ID_LAST) ? '0 : gnt_idx + IDW'(1);
      if (state == ST_START)
        wd <= '0;
      else if (state == ST_WAIT && wd != WD_MAX)
        wd <= wd + WDW'(1);
    end
  end

  // ---- operand / result holding registers ----
  always_ff @(posedge clk) begin
    if (grant_fire) begin
      op_reg <= op_sel;
      id_reg <= gnt_idx;
    end
    if (done_fire) begin
      y_reg   <= eng_y;
      err_reg <= 1'b0;
    end else if (timeout_fire) begin
      y_reg   <= '0;
      err_reg <= 1'b1;
    end
  end

  // ---- output logic ----
  // Everything is forced low while rst is high, except eng_rst which is
  // held high so the engine is re-preloaded for the whole reset.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_y     = '0;
    rsp_err   = 1'b0;
    eng_rst   = rst;
    eng_en    = 1'b0;
    eng_x     = '0;
    busy      = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: req_ready = gnt;
        ST_LOAD: begin
          eng_rst = 1'b1;
          eng_x   = op_reg;
          busy    = 1'b1;
        end
        ST_START: begin
          eng_en = 1'b1;
          eng_x  = op_reg;
          busy   = 1'b1;
        end
        ST_WAIT: begin
          // Hung engine is re-preloaded on the way out to RESP.
          eng_rst = timeout_fire;
          eng_x   = op_reg;
          busy    = 1'b1;
        end
        ST_RESP: begin
          rsp_valid = 1'b1;
          rsp_id    = id_reg;
          rsp_y     = y_reg;
          rsp_err   = err_reg;
          busy      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
module tb_cordic_sched;

  localparam int NREQ    = 4;
  localparam int XW      = 32;
  localparam int YW      = 64;
  localparam int TIMEOUT = 40;
  localparam int IDW     = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*XW-1:0]  req_x;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [YW-1:0]       rsp_y;
  logic                rsp_err;
  logic                eng_rst;
  logic                eng_en;
  logic [XW-1:0]       eng_x;
  logic [YW-1:0]       eng_y;
  logic                eng_valid;
  logic                busy;

  always #5 clk = ~clk;

  cordic_sched #(
    .NREQ    (NREQ),
    .XW      (XW),
    .YW      (YW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .eng_rst   (eng_rst),
    .eng_en    (eng_en),
    .eng_x     (eng_x),
    .eng_y     (eng_y),
    .eng_valid (eng_valid),
    .busy      (busy)
  );

  // Stand-in engine result: an easily hand-checked scramble of the operand.
  function automatic logic [YW-1:0] model_y(input logic [XW-1:0] x);
    return {x ^ 32'hA5A5_5A5A, ~x};
  endfunction

  // Engine model: preload on eng_rst, eng_valid 34 cycles after eng_en.
  int             eng_lat  = 34;
  bit             eng_hang = 1'b0;
  logic           spur     = 1'b0;
  logic [YW-1:0]  spur_y   = '0;
  logic           m_valid  = 1'b0;
  logic [YW-1:0]  m_y      = '0;
  logic [XW-1:0]  m_x      = '0;
  logic           m_run    = 1'b0;
  int             m_cnt    = 0;

  assign eng_valid = m_valid | spur;
  assign eng_y     = spur ? spur_y : m_y;

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (eng_rst) begin
      m_x   <= eng_x;
      m_run <= 1'b0;
      m_cnt <= 0;
    end else if (eng_en) begin
      m_run <= 1'b1;
      m_cnt <= 1;
    end else if (m_run) begin
      if (!eng_hang && m_cnt == eng_lat - 1) begin
        m_valid <= 1'b1;
        m_y     <= model_y(m_x);
        m_run   <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  logic [XW-1:0] xw [NREQ];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int g);
    int n;
    #1;
    n = 0;
    g = -1;
    while (req_ready == '0 && n < 300) begin
      step();
      n++;
    end
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
    chk("grant_seen", 64'(req_ready != '0), 64'd1);
  endtask

  // Grant, then count cycles from the grant cycle to rsp_valid; leaves the
  // bench sitting in the RESP cycle.
  task automatic do_txn(input int exp_g);
    int g;
    int lat;
    wait_grant(g);
    chk("txn_grant_id", 64'(g), 64'(exp_g));
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      step();
      lat++;
    end
    chk("txn_latency", 64'(lat), 64'd37);
    chk("txn_rsp_id", 64'(rsp_id), 64'(exp_g));
    chk("txn_rsp_y", rsp_y, model_y(xw[exp_g]));
    chk("txn_rsp_err", 64'(rsp_err), 64'd0);
    chk("txn_ready_idle", 64'(req_ready), 64'd0);
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    spur      = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
  endtask

  initial begin : stim
    int g;
    int n;
    int waitc;
    int rst_pulses;
    int rst_at;
    int exp_order [10];

    xw[0] = 32'h1357_9BDF;
    xw[1] = 32'h2468_ACE0;
    xw[2] = 32'h0001_0000;
    xw[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < NREQ; i++) req_x[i*XW +: XW] = xw[i];

    // Reset state
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    repeat (2) step();
    chk("rst_eng_rst", 64'(eng_rst), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_eng_en", 64'(eng_en), 64'd0);
    chk("rst_eng_x", 64'(eng_x), 64'd0);
    chk("rst_rsp_y", rsp_y, 64'd0);
    req_valid = '0;
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_eng_rst", 64'(eng_rst), 64'd0);

    // Single request from requester 2
    req_valid = 4'b0100;
    wait_grant(g);
    chk("single_ready_vec", 64'(req_ready), 64'h4);
    chk("single_busy_idle", 64'(busy), 64'd0);
    step();
    req_valid = '0;
    chk("single_ready_pulse", 64'(req_ready), 64'd0);
    chk("single_load_rst", 64'(eng_rst), 64'd1);
    chk("single_load_en", 64'(eng_en), 64'd0);
    chk("single_load_x", 64'(eng_x), 64'h0001_0000);
    chk("single_load_busy", 64'(busy), 64'd1);
    step();
    chk("single_start_en", 64'(eng_en), 64'd1);
    chk("single_start_rst", 64'(eng_rst), 64'd0);
    chk("single_start_x", 64'(eng_x), 64'h0001_0000);
    step();
    chk("single_wait_en", 64'(eng_en), 64'd0);
    chk("single_wait_x", 64'(eng_x), 64'h0001_0000);
    n = 3;
    while (!rsp_valid && n < 300) begin
      step();
      n++;
    end
    chk("single_latency", 64'(n), 64'd37);
    chk("single_rsp_id", 64'(rsp_id), 64'd2);
    chk("single_rsp_y", rsp_y, 64'hA5A4_5A5A_FFFE_FFFF);
    chk("single_rsp_err", 64'(rsp_err), 64'd0);
    step();
    chk("single_rsp_drop", 64'(rsp_valid), 64'd0);
    chk("single_idle_busy", 64'(busy), 64'd0);
    chk("single_idle_x", 64'(eng_x), 64'd0);

    // Fairness: all four requesting, then only 0 and 3
    reset_dut();
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 3};
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      do_txn(exp_order[k]);
      if (k == 7) req_valid = 4'b1001;
      if (k == 9) req_valid = 4'b0000;
      step();
      chk("fair_rsp_drop", 64'(rsp_valid), 64'd0);
    end

    // Backpressure with a spurious eng_valid while held in RESP
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    do_txn(0);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        spur   = 1'b1;
        spur_y = 64'hDEAD_BEEF_0BAD_F00D;
      end else begin
        spur = 1'b0;
      end
      step();
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_id", 64'(rsp_id), 64'd0);
      chk("bp_rsp_y", rsp_y, model_y(xw[0]));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    spur      = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("bp_release_drop", 64'(rsp_valid), 64'd0);
    chk("bp_next_grant", 64'(req_ready), 64'h2);
    do_txn(1);
    req_valid = '0;
    step();

    // Spurious eng_valid in IDLE
    spur   = 1'b1;
    spur_y = 64'h0123_4567_89AB_CDEF;
    step();
    spur = 1'b0;
    chk("spur_idle_busy", 64'(busy), 64'd0);
    chk("spur_idle_rsp", 64'(rsp_valid), 64'd0);
    step();
    chk("spur_idle_busy2", 64'(busy), 64'd0);
    chk("spur_idle_ready", 64'(req_ready), 64'd0);

    // Timeout: engine never completes (pointer is 2, only requester 1 asks)
    eng_hang  = 1'b1;
    req_valid = 4'b0010;
    wait_grant(g);
    chk("to_grant_id", 64'(g), 64'd1);
    step();
    req_valid = '0;
    step();
    chk("to_start_en", 64'(eng_en), 64'd1);
    n          = 0;
    waitc      = 0;
    rst_pulses = 0;
    rst_at     = -1;
    while (!rsp_valid && n < 100) begin
      step();
      n++;
      if (!rsp_valid) begin
        waitc++;
        if (eng_rst) begin
          rst_pulses++;
          rst_at = waitc;
        end
      end
    end
    chk("to_wait_cycles", 64'(waitc), 64'd40);
    chk("to_eng_rst_pulses", 64'(rst_pulses), 64'd1);
    chk("to_eng_rst_cycle", 64'(rst_at), 64'd40);
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("to_rsp_err", 64'(rsp_err), 64'd1);
    chk("to_rsp_y", rsp_y, 64'd0);
    chk("to_rsp_id", 64'(rsp_id), 64'd1);
    chk("to_eng_rst_resp", 64'(eng_rst), 64'd0);
    eng_hang  = 1'b0;
    req_valid = 4'b0100;
    step();
    chk("to_rsp_drop", 64'(rsp_valid), 64'd0);
    do_txn(2);
    req_valid = '0;
    step();

    // Reset 10 cycles into WAIT (pointer is 3, requester 1 granted)
    req_valid = 4'b0010;
    wait_grant(g);
    chk("mr_grant_id", 64'(g), 64'd1);
    step();
    req_valid = '0;
    step();
    repeat (10) step();
    chk("mr_in_wait", 64'(busy), 64'd1);
    rst       = 1'b1;
    req_valid = 4'b1111;
    step();
    chk("mr_eng_rst", 64'(eng_rst), 64'd1);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mr_req_ready", 64'(req_ready), 64'd0);
    chk("mr_eng_en", 64'(eng_en), 64'd0);
    chk("mr_eng_x", 64'(eng_x), 64'd0);
    chk("mr_rsp_id", 64'(rsp_id), 64'd0);
    chk("mr_rsp_err", 64'(rsp_err), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mr_first_grant", 64'(req_ready), 64'h1);
    do_txn(0);
    req_valid = '0;
    step();
    chk("mr_final_drop", 64'(rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
